// File: rtl/dcpu16_marb_if.sv
// rtl/dcpu16_marb_if.sv - F-BUS, G-BUS and memory-port signal bundle for the memory arbiter
interface dcpu16_marb_if;
  logic [15:0] f_adr;
  logic [15:0] f_dto;
  logic        f_stb;
  logic        f_wre;
  logic [15:0] f_dti;
  logic        f_ack;
  logic [15:0] g_adr;
  logic [15:0] g_dto;
  logic        g_stb;
  logic        g_wre;
  logic [15:0] g_dti;
  logic        g_ack;
  logic [15:0] m_adr;
  logic [15:0] m_dto;
  logic        m_stb;
  logic        m_wre;
  logic [15:0] m_dti;
  logic        m_ack;

  // Arbiter side
  modport slave (
    input  f_adr, f_dto, f_stb, f_wre,
    output f_dti, f_ack,
    input  g_adr, g_dto, g_stb, g_wre,
    output g_dti, g_ack,
    output m_adr, m_dto, m_stb, m_wre,
    input  m_dti, m_ack
  );

  // Environment side: the two bus masters plus the memory
  modport master (
    output f_adr, f_dto, f_stb, f_wre,
    input  f_dti, f_ack,
    output g_adr, g_dto, g_stb, g_wre,
    input  g_dti, g_ack,
    input  m_adr, m_dto, m_stb, m_wre,
    output m_dti, m_ack
  );
endinterface

// File: rtl/dcpu16_marb.sv
// rtl/dcpu16_marb.sv - two-master arbiter for one simplified-Wishbone memory port with watchdog
module dcpu16_marb #(
  parameter bit         FPRI = 1'b0,
  parameter logic [7:0] TMO  = 8'd255
) (
  input  logic          clk,
  input  logic          rst,
  dcpu16_marb_if.slave  bus,
  output logic          tmo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNTF = 2'd1,
    GNTG = 2'd2
  } state_t;

  localparam logic LST_F = 1'b0;
  localparam logic LST_G = 1'b1;

  state_t     state;
  logic       lst;
  logic [7:0] wdt;

  logic gnt_f;
  logic gnt_g;
  logic cur_stb;
  logic ack_v;
  logic expire;

  always_comb begin
    gnt_f   = (state == GNTF);
    gnt_g   = (state == GNTG);
    cur_stb = (gnt_f & bus.f_stb) | (gnt_g & bus.g_stb);
    ack_v   = cur_stb & bus.m_ack;
    // A real ack in the expiry cycle takes precedence over the watchdog
    expire  = (TMO != 8'd0) && cur_stb && !bus.m_ack && (wdt == TMO - 8'd1);

    bus.m_adr = 16'h0000;
    bus.m_dto = 16'h0000;
    bus.m_stb = 1'b0;
    bus.m_wre = 1'b0;
    if (gnt_f && bus.f_stb) begin
      bus.m_adr = bus.f_adr;
      bus.m_dto = bus.f_dto;
      bus.m_stb = 1'b1;
      bus.m_wre = bus.f_wre;
    end else if (gnt_g && bus.g_stb) begin
      bus.m_adr = bus.g_adr;
      bus.m_dto = bus.g_dto;
      bus.m_stb = 1'b1;
      bus.m_wre = bus.g_wre;
    end

    // Return paths depend only on state, never on the other master's strobe
    bus.f_ack = gnt_f & (ack_v | expire);
    bus.g_ack = gnt_g & (ack_v | expire);
    bus.f_dti = (gnt_f && !expire) ? bus.m_dti : 16'h0000;
    bus.g_dti = (gnt_g && !expire) ? bus.m_dti : 16'h0000;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      lst   <= LST_G;
      wdt   <= 8'd0;
      tmo   <= 1'b0;
    end else begin
      tmo <= 1'b0;
      case (state)
        IDLE: begin
          wdt <= 8'd0;
          if (bus.f_stb && (!bus.g_stb || FPRI || (lst == LST_G))) begin
            state <= GNTF;
          end else if (bus.g_stb) begin
            state <= GNTG;
          end
        end
        GNTF, GNTG: begin
          if (!cur_stb) begin
            state <= IDLE;
          end else if (ack_v) begin
            state <= IDLE;
            lst   <= gnt_g;
          end else if (expire) begin
            state <= IDLE;
            lst   <= gnt_g;
            tmo   <= 1'b1;
          end else if (wdt != 8'hFF) begin
            wdt <= wdt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcpu16_marb.sv
// tb/tb_dcpu16_marb.sv - scoreboard bench for dcpu16_marb, round-robin and fixed-priority instances
module tb_dcpu16_marb;

  logic        clk;
  logic        rst_n;
  logic        tmo_a;
  logic        tmo_b;
  logic        ack_en;
  logic        use_fix;
  logic [15:0] fix_dti;

  int checks;
  int errors;

  typedef struct {
    logic        g;
    logic [15:0] dti;
  } exp_t;
  exp_t sb[$];

  dcpu16_marb_if ifa ();
  dcpu16_marb_if ifb ();

  dcpu16_marb #(.FPRI(1'b0), .TMO(8'd4)) u_rr (
    .clk (clk),
    .rst (rst_n),
    .bus (ifa.slave),
    .tmo (tmo_a)
  );

  dcpu16_marb #(.FPRI(1'b1), .TMO(8'd4)) u_fp (
    .clk (clk),
    .rst (rst_n),
    .bus (ifb.slave),
    .tmo (tmo_b)
  );

  // Memory models: zero-wait when enabled, data derived from the address
  assign ifa.m_ack = ack_en & ifa.m_stb;
  assign ifa.m_dti = use_fix ? fix_dti : (ifa.m_adr ^ 16'h5A5A);
  assign ifb.m_ack = ifb.m_stb;
  assign ifb.m_dti = ifb.m_adr ^ 16'h5A5A;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic g, input logic [15:0] dti);
    exp_t e;
    e.g   = g;
    e.dti = dti;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (ifa.f_ack || ifa.g_ack)) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_ack", {30'd0, ifa.g_ack, ifa.f_ack}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("sb_who", {30'd0, ifa.g_ack, ifa.f_ack}, e.g ? 32'd2 : 32'd1);
        chk("sb_dti", e.g ? {16'd0, ifa.g_dti} : {16'd0, ifa.f_dti}, {16'd0, e.dti});
      end
    end
  end

  initial begin
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    ack_en  = 1'b0;
    use_fix = 1'b0;
    fix_dti = 16'h0000;
    ifa.f_adr = 16'h0; ifa.f_dto = 16'h0; ifa.f_stb = 1'b0; ifa.f_wre = 1'b0;
    ifa.g_adr = 16'h0; ifa.g_dto = 16'h0; ifa.g_stb = 1'b0; ifa.g_wre = 1'b0;
    ifb.f_adr = 16'h0; ifb.f_dto = 16'h0; ifb.f_stb = 1'b0; ifb.f_wre = 1'b0;
    ifb.g_adr = 16'h0; ifb.g_dto = 16'h0; ifb.g_stb = 1'b0; ifb.g_wre = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_a_mstb", {31'd0, ifa.m_stb}, 32'd0);
    chk("rst_a_tmo", {31'd0, tmo_a}, 32'd0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_a_out", {ifa.m_adr, 13'd0, ifa.m_stb, ifa.f_ack, ifa.g_ack}, 32'd0);
    chk("idle_b_out", {ifb.m_adr, 13'd0, ifb.m_stb, ifb.f_ack, ifb.g_ack}, 32'd0);
    chk("idle_b_tmo", {31'd0, tmo_b}, 32'd0);

    // F read alone
    tick();
    ifa.f_adr = 16'h0100; ifa.f_stb = 1'b1; use_fix = 1'b1; fix_dti = 16'hBEEF; ack_en = 1'b1;
    push(1'b0, 16'hBEEF);
    @(negedge clk);
    chk("t1_idle_mstb", {31'd0, ifa.m_stb}, 32'd0);
    @(negedge clk);
    chk("t1_madr", {16'd0, ifa.m_adr}, 32'h0100);
    chk("t1_fack", {31'd0, ifa.f_ack}, 32'd1);
    chk("t1_gack", {31'd0, ifa.g_ack}, 32'd0);
    tick();
    ifa.f_stb = 1'b0; use_fix = 1'b0;

    // Round-robin tie from reset
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    ifa.f_adr = 16'h0200; ifa.g_adr = 16'h0300; ifa.f_stb = 1'b1; ifa.g_stb = 1'b1;
    push(1'b0, 16'h0200 ^ 16'h5A5A);
    push(1'b1, 16'h0300 ^ 16'h5A5A);
    push(1'b0, 16'h0200 ^ 16'h5A5A);
    push(1'b1, 16'h0300 ^ 16'h5A5A);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("t2_fack_c%0d", i), {31'd0, ifa.f_ack}, {31'd0, (i % 4) == 1});
      chk($sformatf("t2_gack_c%0d", i), {31'd0, ifa.g_ack}, {31'd0, (i % 4) == 3});
      if (ifa.f_ack) chk("t2_gdti_zero", {16'd0, ifa.g_dti}, 32'd0);
    end
    tick();
    ifa.f_stb = 1'b0; ifa.g_stb = 1'b0;

    // Fixed-priority tie
    ifb.f_adr = 16'h0700; ifb.g_adr = 16'h0800; ifb.f_stb = 1'b1; ifb.g_stb = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("t3_fack_c%0d", i), {31'd0, ifb.f_ack}, {31'd0, (i % 2) == 1});
      chk($sformatf("t3_gack_c%0d", i), {31'd0, ifb.g_ack}, 32'd0);
      if (i % 2 == 1) chk("t3_fdti", {16'd0, ifb.f_dti}, {16'd0, 16'h0700 ^ 16'h5A5A});
    end
    tick();
    ifb.f_stb = 1'b0; ifb.g_stb = 1'b0;

    // Watchdog with memory never acking
    ack_en = 1'b0;
    ifa.g_adr = 16'h0020; ifa.g_dto = 16'h1234; ifa.g_wre = 1'b1; ifa.g_stb = 1'b1;
    push(1'b1, 16'h0000);
    @(negedge clk);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk($sformatf("t4_mstb_c%0d", i), {31'd0, ifa.m_stb}, 32'd1);
      chk($sformatf("t4_gack_c%0d", i), {31'd0, ifa.g_ack}, {31'd0, i == 4});
      chk($sformatf("t4_tmo_c%0d", i), {31'd0, tmo_a}, 32'd0);
    end
    chk("t4_mwr", {ifa.m_dto, ifa.m_adr}, 32'h1234_0020);
    tick();
    ifa.g_stb = 1'b0; ifa.g_wre = 1'b0;
    @(negedge clk);
    chk("t4_tmo_pulse", {31'd0, tmo_a}, 32'd1);
    chk("t4_idle_mstb", {31'd0, ifa.m_stb}, 32'd0);
    @(negedge clk);
    chk("t4_tmo_single", {31'd0, tmo_a}, 32'd0);

    // Abort with a pending G request
    tick();
    ifa.f_adr = 16'h0040; ifa.g_adr = 16'h0050; ifa.f_stb = 1'b1; ifa.g_stb = 1'b1;
    push(1'b1, 16'h0050 ^ 16'h5A5A);
    @(negedge clk);
    @(negedge clk);
    chk("t5_gntf", {15'd0, ifa.m_stb, ifa.m_adr}, 32'h0001_0040);
    tick();
    ifa.f_stb = 1'b0; ack_en = 1'b1;
    #1;
    chk("t5_abort_mstb", {31'd0, ifa.m_stb}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("t5_bubble", {31'd0, ifa.m_stb}, 32'd0);
    @(negedge clk);
    chk("t5_gntg", {14'd0, ifa.m_stb, ifa.g_ack, ifa.m_adr}, 32'h0003_0050);
    tick();
    ifa.g_stb = 1'b0;

    // Asynchronous reset mid-GNTG
    ack_en = 1'b0;
    ifa.g_adr = 16'h0060; ifa.g_stb = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t6_pre_mstb", {31'd0, ifa.m_stb}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_out", {ifa.m_adr, 14'd0, ifa.m_stb, ifa.g_ack}, 32'd0);
    ifa.g_stb = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    ack_en = 1'b1;
    ifa.f_adr = 16'h0080; ifa.g_adr = 16'h0090; ifa.f_stb = 1'b1; ifa.g_stb = 1'b1;
    push(1'b0, 16'h0080 ^ 16'h5A5A);
    push(1'b1, 16'h0090 ^ 16'h5A5A);
    @(negedge clk);
    @(negedge clk);
    chk("t6_first_f", {31'd0, ifa.f_ack}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("t6_then_g", {31'd0, ifa.g_ack}, 32'd1);
    tick();
    ifa.f_stb = 1'b0; ifa.g_stb = 1'b0;

    repeat (3) tick();
    chk("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
